// File: rtl/cbus_pkg.sv
// Shared CBUS bus payload types used by every CBUS initiator and target.
package cbus_pkg;

    localparam int unsigned CBUS_AW   = 32;
    localparam int unsigned CBUS_DW   = 32;
    localparam int unsigned CBUS_LENW = 8;

    typedef struct packed {
        logic                 valid;
        logic                 is_write;
        logic [1:0]           size;
        logic [CBUS_AW-1:0]   addr;
        logic [CBUS_DW/8-1:0] strobe;
        logic [CBUS_DW-1:0]   data;
        logic [CBUS_LENW-1:0] len;
    } cbus_req_t;

    typedef struct packed {
        logic               ready;
        logic               last;
        logic [CBUS_DW-1:0] data;
    } cbus_resp_t;

endpackage

// File: rtl/cbus_ram_pkg.sv
// Local types and constants for the CBUS RAM slave.
package cbus_ram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BURST = 2'd2
    } state_t;

    // Byte address at and above which beats are out of range when bounds checking is built in.
    localparam logic [31:0] PHYS_LIMIT = 32'h0000_3000;
    localparam logic [31:0] FILL_WORD  = 32'hDEAD_BEEF;

endpackage

// File: rtl/ram_bank32.sv
// Single-port WORDS x 32 RAM: combinational read, synchronous byte-strobed write.
module ram_bank32 #(
    parameter int unsigned WORDS = 4096,
    parameter int unsigned AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata_c
);

    logic [31:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata_c = mem[addr];

endmodule

// File: rtl/cbus_ram_slave.sv
// CBUS burst RAM target with programmable initial wait latency.
// Optional physical-limit checking is built in with CBUS_RAM_BOUNDS_CHECK_EN.
module cbus_ram_slave
    import cbus_pkg::*;
    import cbus_ram_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 4096,
    parameter int unsigned LATENCY   = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  cbus_req_t  creq,
    output cbus_resp_t cresp,
    output logic       err
);

    localparam int unsigned IW = $clog2(MEM_WORDS);
    localparam int unsigned LW = CBUS_LENW;

    state_t        state;
    logic [29:0]   base_word;
    logic          is_wr;
    logic [LW-1:0] len_q;
    logic [LW-1:0] beat;
    logic [LW-1:0] beat_nxt;
    logic [3:0]    wcnt;
    logic          ready_q;
    logic          last_q;

    logic          beat_done_c;
    logic [30:0]   word_unwrapped_c;
    logic [IW-1:0] mem_idx_c;
    logic          oob_c;
    logic          we_c;
    logic [31:0]   rdata_c;

    assign beat_nxt         = beat + LW'(1);
    assign beat_done_c      = ready_q & creq.valid;
    assign word_unwrapped_c = 31'(base_word) + 31'(beat);
    assign mem_idx_c        = word_unwrapped_c[IW-1:0];

`ifdef CBUS_RAM_BOUNDS_CHECK_EN
    logic err_q;
    assign oob_c = {2'b00, word_unwrapped_c, 2'b00} >= 35'(PHYS_LIMIT);
    assign err   = err_q;
`else
    assign oob_c = 1'b0;
    assign err   = 1'b0;
`endif

    // Writes in a reset cycle are dropped so reset never disturbs contents.
    assign we_c = beat_done_c & is_wr & resetn & ~oob_c;

    ram_bank32 #(
        .WORDS (MEM_WORDS),
        .AW    (IW)
    ) u_ram (
        .clk     (clk),
        .we      (we_c),
        .be      (creq.strobe),
        .addr    (mem_idx_c),
        .wdata   (creq.data),
        .rdata_c (rdata_c)
    );

    always_comb begin
        cresp       = '0;
        cresp.ready = ready_q;
        cresp.last  = last_q;
        if (ready_q) begin
            cresp.data = oob_c ? FILL_WORD : rdata_c;
        end
    end

    // Burst control FSM; ready/last are registered from the next-state decision.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            beat    <= '0;
            wcnt    <= '0;
            ready_q <= 1'b0;
            last_q  <= 1'b0;
`ifdef CBUS_RAM_BOUNDS_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (creq.valid) begin
                        base_word <= creq.addr[31:2];
                        is_wr     <= creq.is_write;
                        len_q     <= creq.len;
                        beat      <= '0;
                        wcnt      <= 4'(LATENCY);
                        if (LATENCY == 0) begin
                            state   <= ST_BURST;
                            ready_q <= 1'b1;
                            last_q  <= (creq.len == '0);
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!creq.valid) begin
                        state <= ST_IDLE;
                    end else begin
                        wcnt <= wcnt - 4'd1;
                        if (wcnt == 4'd1) begin
                            state   <= ST_BURST;
                            ready_q <= 1'b1;
                            last_q  <= (len_q == '0);
                        end
                    end
                end
                ST_BURST: begin
                    if (!creq.valid || beat == len_q) begin
                        state   <= ST_IDLE;
                        ready_q <= 1'b0;
                        last_q  <= 1'b0;
                    end else begin
                        beat   <= beat_nxt;
                        last_q <= (beat_nxt == len_q);
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    ready_q <= 1'b0;
                    last_q  <= 1'b0;
                end
            endcase
`ifdef CBUS_RAM_BOUNDS_CHECK_EN
            if (beat_done_c && oob_c) begin
                err_q <= 1'b1;
            end
`endif
        end
    end

    logic unused_ok;
    assign unused_ok = ^{creq.size, creq.addr[1:0], word_unwrapped_c};

endmodule

// File: tb/tb_cbus_ram_slave.sv
// Scoreboard bench for cbus_ram_slave: reference memory model, per-beat data/last/err checks.
module tb_cbus_ram_slave;
    import cbus_pkg::*;
    import cbus_ram_pkg::*;

    localparam int unsigned MEM_WORDS = 4096;
    localparam int unsigned LATENCY   = 2;
`ifdef CBUS_RAM_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       resetn;
    cbus_req_t  creq;
    cbus_resp_t cresp;
    logic       err;

    cbus_ram_slave #(
        .MEM_WORDS (MEM_WORDS),
        .LATENCY   (LATENCY)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .creq   (creq),
        .cresp  (cresp),
        .err    (err)
    );

    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] model [int];
    bit          model_err = 1'b0;
    logic [31:0] exp_q [$];
    logic [31:0] wbuf [4];

    function automatic int widx(input logic [31:0] addr, input int b);
        return int'((longint'(addr >> 2) + longint'(b)) % longint'(MEM_WORDS));
    endfunction

    function automatic bit oob_beat(input logic [31:0] addr, input int b);
        longint ua;
        ua = (longint'(addr >> 2) + longint'(b)) * 4;
        return BOUNDS_EN && (ua >= longint'(PHYS_LIMIT));
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (s[i]) r[8*i +: 8] = nw[8*i +: 8];
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One burst; abort_at drops valid when that beat is presented, rst_at pulses reset there.
    task automatic burst(input bit wr, input logic [31:0] addr, input int len,
                         input logic [3:0] strb, input int abort_at, input int rst_at);
        int          cyc;
        int          b;
        bit          first;
        logic [31:0] exp;
        cyc   = 0;
        b     = 0;
        first = 1'b1;
        exp_q.delete();
        if (!wr) begin
            for (int k = 0; k <= len; k++) begin
                if (oob_beat(addr, k)) exp_q.push_back(FILL_WORD);
                else if (model.exists(widx(addr, k))) exp_q.push_back(model[widx(addr, k)]);
                else exp_q.push_back(32'h0);
            end
        end
        creq          = '0;
        creq.valid    = 1'b1;
        creq.is_write = wr;
        creq.size     = 2'b10;
        creq.addr     = addr;
        creq.len      = 8'(len);
        creq.strobe   = strb;
        creq.data     = wbuf[0];
        forever begin
            step();
            cyc++;
            if (cyc > 40) begin
                vectors++;
                miscompares++;
                $display("FAIL timeout addr=%h: no completion within 40 cycles", addr);
                break;
            end
            if (!cresp.ready) continue;
            if (first) begin
                first = 1'b0;
                vectors++;
                if (cyc !== LATENCY + 1) begin
                    miscompares++;
                    $display("FAIL latency addr=%h: ready after %0d cycles, need %0d", addr, cyc, LATENCY + 1);
                end
            end
            if (b == abort_at) begin
                creq.valid = 1'b0;
                step();
                vectors++;
                if (cresp.ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL abort_idle addr=%h: ready=%b, need 0", addr, cresp.ready);
                end
                break;
            end
            if (b == rst_at) begin
                resetn = 1'b0;
                step();
                model_err = 1'b0;
                vectors++;
                if ({cresp.ready, cresp.last, cresp.data, err} !== 35'h0) begin
                    miscompares++;
                    $display("FAIL reset_mid: ready=%b last=%b data=%h err=%b, need all 0",
                             cresp.ready, cresp.last, cresp.data, err);
                end
                resetn     = 1'b1;
                creq.valid = 1'b0;
                break;
            end
            vectors++;
            if (cresp.last !== (b == len) || err !== model_err) begin
                miscompares++;
                $display("FAIL beat_flags addr=%h beat=%0d: last=%b err=%b, need last=%b err=%b",
                         addr, b, cresp.last, err, (b == len), model_err);
            end
            if (wr) begin
                creq.data = wbuf[b];
                if (oob_beat(addr, b)) model_err = 1'b1;
                else model[widx(addr, b)] = merge(model.exists(widx(addr, b)) ?
                                                  model[widx(addr, b)] : 32'h0, wbuf[b], strb);
            end else begin
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
                vectors++;
                if (cresp.data !== exp) begin
                    miscompares++;
                    $display("FAIL read_data addr=%h beat=%0d: got %h, need %h", addr, b, cresp.data, exp);
                end
                if (oob_beat(addr, b)) model_err = 1'b1;
            end
            if (b == len) begin
                step();
                vectors++;
                if (cresp.ready !== 1'b0 || cresp.last !== 1'b0 || err !== model_err) begin
                    miscompares++;
                    $display("FAIL post_last addr=%h: ready=%b last=%b err=%b, need 0 0 %b",
                             addr, cresp.ready, cresp.last, err, model_err);
                end
                break;
            end
            b++;
        end
        creq.valid = 1'b0;
        step();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        creq   = '0;
        step();
        step();
        vectors++;
        if ({cresp.ready, cresp.last, cresp.data, err} !== 35'h0) begin
            miscompares++;
            $display("FAIL reset_state: ready=%b last=%b data=%h err=%b, need all 0",
                     cresp.ready, cresp.last, cresp.data, err);
        end
        resetn = 1'b1;
        step();
    endtask

    task automatic test_single_read();
        wbuf[0] = 32'h1234_5678;
        burst(1'b1, 32'h40, 0, 4'hF, -1, -1);
        burst(1'b0, 32'h40, 0, 4'hF, -1, -1);
    endtask

    task automatic test_burst();
        for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
        burst(1'b1, 32'h100, 3, 4'hF, -1, -1);
        burst(1'b0, 32'h100, 3, 4'hF, -1, -1);
    endtask

    task automatic test_strobe();
        wbuf[0] = 32'hAABB_CCDD;
        burst(1'b1, 32'h80, 0, 4'hF, -1, -1);
        wbuf[0] = 32'h1122_3344;
        burst(1'b1, 32'h80, 0, 4'b0101, -1, -1);
        exp_q.delete();
        burst(1'b0, 32'h80, 0, 4'hF, -1, -1);
        vectors++;
        if (model[32'h20] !== 32'hAA22_CC44) begin
            miscompares++;
            $display("FAIL strobe_model: model %h, need AA22CC44", model[32'h20]);
        end
    endtask

    task automatic test_wrap();
        wbuf[0] = 32'hA0A0_A0A0;
        wbuf[1] = 32'hB0B0_B0B0;
        burst(1'b1, 32'h3FFC, 1, 4'hF, -1, -1);
        burst(1'b0, 32'h3FFC, 1, 4'hF, -1, -1);
        burst(1'b0, 32'h0000, 0, 4'hF, -1, -1);
    endtask

    task automatic test_abort();
        for (int i = 0; i < 4; i++) wbuf[i] = 32'h5000 + 32'(i);
        burst(1'b1, 32'h200, 3, 4'hF, -1, -1);
        for (int i = 0; i < 4; i++) wbuf[i] = 32'h7700 + 32'(i);
        burst(1'b1, 32'h200, 3, 4'hF, 1, -1);
        burst(1'b0, 32'h200, 3, 4'hF, -1, -1);
    endtask

    task automatic test_reset_mid();
        burst(1'b0, 32'h100, 3, 4'hF, -1, 1);
        burst(1'b0, 32'h100, 3, 4'hF, -1, -1);
        wbuf[0] = 32'hCAFE_F00D;
        burst(1'b1, 32'h300, 0, 4'hF, -1, -1);
        wbuf[0] = 32'hFFFF_FFFF;
        burst(1'b1, 32'h300, 0, 4'hF, -1, 0);
        burst(1'b0, 32'h300, 0, 4'hF, -1, -1);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        int          l;
        for (int k = 0; k < 6; k++) begin
            a = 32'h400 + 32'(4 * $urandom_range(0, 60));
            l = $urandom_range(0, 3);
            for (int i = 0; i < 4; i++) wbuf[i] = $urandom;
            burst(1'b1, a, l, 4'hF, -1, -1);
            for (int i = 0; i < 4; i++) wbuf[i] = $urandom;
            burst(1'b1, a, l, 4'($urandom_range(1, 15)), -1, -1);
            burst(1'b0, a, l, 4'hF, -1, -1);
        end
    endtask

    task automatic test_bounds();
        wbuf[0] = 32'h0BAD_0BAD;
        burst(1'b0, PHYS_LIMIT, 0, 4'hF, -1, -1);
        burst(1'b1, PHYS_LIMIT, 0, 4'hF, -1, -1);
        burst(1'b0, PHYS_LIMIT - 32'h4, 1, 4'hF, -1, -1);
        vectors++;
        if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_sticky: err=%b, need 1", err);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_burst();
        test_strobe();
`ifndef CBUS_RAM_BOUNDS_CHECK_EN
        test_wrap();
`endif
        test_abort();
        test_reset_mid();
        test_back_to_back();
`ifdef CBUS_RAM_BOUNDS_CHECK_EN
        test_bounds();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cbus_ram_slave.md
CBUS_RAM_SLAVE -- requirements
Module: cbus_ram_slave

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 4096; memory depth in 32-bit words, power of two.
REQ-002 SHALL have parameter LATENCY, default 2; wait cycles from request acceptance to first data beat; legal range 0..15.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn, input, 1, synchronous active-low reset.
REQ-005 SHALL have port creq, input, cbus_req_t, the burst request from the initiator/arbiter, with fields valid, is_write, size, addr, strobe, data and len.
REQ-006 SHALL have port cresp, output, cbus_resp_t, the response to the initiator, with fields ready, last and data.
REQ-007 SHALL have port err, output, 1, sticky out-of-range flag.

Function
REQ-008 SHALL use a three-state FSM: IDLE, WAIT, BURST.
REQ-009 SHALL, in IDLE with creq.valid=1, latch addr, is_write and len, and load beat=0 and wcnt=LATENCY.
- Next state is WAIT if LATENCY>0, else BURST.
REQ-010 SHALL, in WAIT, decrement wcnt each cycle and enter BURST on the cycle after wcnt reaches 1; cresp.ready=0 throughout WAIT.
REQ-011 SHALL, in BURST, drive cresp.ready=1 every cycle; each cycle with ready=1 and valid=1 is one completed beat.
REQ-012 SHALL compute the beat word index as ((latched addr>>2)+beat) mod MEM_WORDS; addr[1:0] ignored; increments wrap at the top of memory.
REQ-013 SHALL, for reads, drive cresp.data combinationally from the memory word at the current beat index; data is don't-care when ready=0.
REQ-014 SHALL, for writes, update only the bytes enabled by creq.strobe with creq.data on each completed beat.
- The write is visible to a read beat starting the following cycle.
REQ-015 SHALL assert cresp.last together with ready on the beat where beat==len; len=0 means a single-beat burst.
REQ-016 SHALL return to IDLE after the last beat and hold ready=0 for at least one cycle before the next burst is accepted.
REQ-017 SHALL treat creq.valid falling in WAIT or BURST as an abort: return to IDLE next cycle with no further memory writes.
REQ-018 SHALL ignore changes to creq fields other than valid, data and strobe during a burst; the latched values govern the burst.
REQ-019 SHALL hold cresp.ready=0 and cresp.last=0 in IDLE and WAIT.

Reset
REQ-020 SHALL, while resetn=0 at a clock edge, enter IDLE, clear beat and wcnt, and drive ready=0, last=0, data=0 and err=0.
REQ-021 SHALL NOT modify memory contents on reset, including reset mid-burst; a write beat in the reset cycle is dropped.

Configuration
REQ-022 SHALL, with CBUS_RAM_BOUNDS_CHECK_EN defined, check each completed beat against PHYS_LIMIT, the byte limit in the package. For an out-of-range beat (unwrapped address >= PHYS_LIMIT):
- a read returns 32'hDEADBEEF;
- a write is dropped;
- err is set and stays set until reset.
REQ-023 SHALL, without CBUS_RAM_BOUNDS_CHECK_EN, tie err to 0 and apply only the modulo wrap of REQ-012.

Structure
REQ-024 SHALL place the FSM state enum, PHYS_LIMIT and the DEADBEEF fill constant in package cbus_ram_pkg; cbus_req_t and cbus_resp_t remain in the existing shared header.
REQ-025 SHALL instantiate one sub-module, ram_bank32.
- Single-port, MEM_WORDS x 32, byte-write strobe.
- Combinational read, synchronous write.
- No reset of contents.

Verification
REQ-026 Single read: preload word 0x10 = 32'h12345678, LATENCY=2; read addr 0x40, len=0 -> ready and last high exactly 3 cycles after acceptance, data=12345678.
REQ-027 Burst write then read, len=3: write addr 0x100 with data 1,2,3,4 and strobe 4'hF, then read back the same burst -> 1,2,3,4 on consecutive cycles; last only on the 4th beat.
REQ-028 Strobe: word 0x20 = 32'hAABBCCDD; write 32'h11223344 with strobe 4'b0101 -> read returns 32'hAA22CC44.
REQ-029 Wrap, macro undefined: MEM_WORDS=4096; read addr 0x3FFC, len=1 -> second beat returns word 0; err stays 0.
REQ-030 Abort and reset:
- drop valid after beat 1 of a len=3 write -> only word 0 written, IDLE next cycle;
- resetn=0 mid-read -> ready=0 next cycle, memory unchanged.
REQ-031 Bounds, macro defined: read at PHYS_LIMIT -> data 32'hDEADBEEF and err=1; a subsequent write there leaves memory unchanged.
